// File: rtl/tune_capture.sv
// Recovers a square-wave note sequence (half-period and period count per note,
// up to four notes) from an asynchronous pwm line, ready to replay into the player.
module tune_capture #(
  parameter int TIMEOUT = 1000,
  parameter int TOL     = 1,
  parameter int CNTW    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            arm,
  input  logic            pwm,
  output logic [CNTW-1:0] freq0,
  output logic [CNTW-1:0] freq1,
  output logic [CNTW-1:0] freq2,
  output logic [CNTW-1:0] freq3,
  output logic [CNTW-1:0] dur0,
  output logic [CNTW-1:0] dur1,
  output logic [CNTW-1:0] dur2,
  output logic [CNTW-1:0] dur3,
  output logic [2:0]      noteCount,
  output logic            capturing,
  output logic            done,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] TOL_C     = CNTW'(TOL);
  localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT - 1);

  state_t          state_r, state_next_s;
  logic            sync1_r, sync2_r, prev_r;
  logic            rise_s, same_s, timeout_s;
  logic [CNTW-1:0] cnt_r, pcur_r, period_s, diff_s;
  logic [CNTW-1:0] freq_r [4];
  logic [CNTW-1:0] dur_r  [4];
  logic [2:0]      note_count_r;
  logic [1:0]      open_idx_s;
  logic            capturing_r, done_r, overflow_r;

  assign rise_s = sync2_r & ~prev_r;

  // Period measurement, note matching and next-state decision.
  always_comb begin
    state_next_s = state_r;
    period_s     = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;
    if (period_s >= pcur_r) begin
      diff_s = period_s - pcur_r;
    end else begin
      diff_s = pcur_r - period_s;
    end
    same_s     = (note_count_r != 3'd0) && (diff_s <= TOL_C);
    timeout_s  = (cnt_r == TIMEOUT_C);
    open_idx_s = note_count_r[1:0] - 2'd1;
    if (arm) begin
      state_next_s = ARMED;
    end else begin
      case (state_r)
        IDLE:    state_next_s = IDLE;
        ARMED:   state_next_s = rise_s ? MEASURE : ARMED;
        MEASURE: begin
          if (rise_s) begin
            if (note_count_r == 3'd4 && !same_s) begin
              state_next_s = DONE;
            end else begin
              state_next_s = MEASURE;
            end
          end else if (timeout_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = MEASURE;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Input synchronizer and result datapath; arm outranks any edge or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      prev_r       <= 1'b0;
      cnt_r        <= '0;
      pcur_r       <= '0;
      note_count_r <= 3'd0;
      capturing_r  <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        freq_r[i] <= '0;
        dur_r[i]  <= '0;
      end
    end else begin
      sync1_r <= pwm;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (arm) begin
        cnt_r        <= '0;
        pcur_r       <= '0;
        note_count_r <= 3'd0;
        capturing_r  <= 1'b1;
        done_r       <= 1'b0;
        overflow_r   <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          freq_r[i] <= '0;
          dur_r[i]  <= '0;
        end
      end else begin
        case (state_r)
          ARMED: begin
            if (rise_s) begin
              cnt_r  <= '0;
              pcur_r <= '0;
            end
          end
          MEASURE: begin
            if (rise_s) begin
              cnt_r <= '0;
              if (same_s) begin
                if (dur_r[open_idx_s] != CNT_MAX) begin
                  dur_r[open_idx_s] <= dur_r[open_idx_s] + CNT_ONE;
                end
              end else if (note_count_r != 3'd4) begin
                pcur_r                     <= period_s;
                freq_r[note_count_r[1:0]]  <= period_s >> 1;
                dur_r[note_count_r[1:0]]   <= CNT_ONE;
                note_count_r               <= note_count_r + 3'd1;
              end else begin
                overflow_r  <= 1'b1;
                capturing_r <= 1'b0;
                done_r      <= 1'b1;
              end
            end else begin
              if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
              end
              if (timeout_s) begin
                capturing_r <= 1'b0;
                done_r      <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign freq0     = freq_r[0];
  assign freq1     = freq_r[1];
  assign freq2     = freq_r[2];
  assign freq3     = freq_r[3];
  assign dur0      = dur_r[0];
  assign dur1      = dur_r[1];
  assign dur2      = dur_r[2];
  assign dur3      = dur_r[3];
  assign noteCount = note_count_r;
  assign capturing = capturing_r;
  assign done      = done_r;
  assign overflow  = overflow_r;

endmodule

// File: doc/tune_capture.md
Name: tune_capture

Overview:
- Receive-side counterpart of the tune player. Monitors a square-wave audio line, such as the pwm output of the tune player, and recovers the note sequence: per-note half-period (freq) and period count (dur) for up to 4 notes.
- Sits beside the player for loopback self-test and for decoding externally supplied tunes.
- Output register layout matches the player's freq0..3/dur0..3 inputs so captured values can be replayed directly.

Parameters:
- TIMEOUT, 1000: clk cycles with no rising edge that end a capture.
- TOL, 1: max |P - Pcur| in clk cycles for a period to count as the same note.
- CNTW, 32: width of period counter and freq/dur outputs.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle pulse; clears results and starts a new capture
- pwm  in  1  square-wave line under test; asynchronous to clk
- freq0..freq3  out  CNTW each  captured half-period of notes 0..3, in clk cycles
- dur0..dur3  out  CNTW each  captured full-period count of notes 0..3
- noteCount  out  3  number of valid notes, 0..4
- capturing  out  1  high from arm until capture ends
- done  out  1  high after capture ends; cleared by arm or reset
- overflow  out  1  a 5th distinct note was detected

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All freq/dur outputs, noteCount, capturing, done and overflow go to 0.
  - Synchronizer flops go to 0.
  - Reset may be asserted at any point, including mid-capture; the same clear applies.
- Input sampling:
  - pwm passes through a 2-flop synchronizer plus one edge-detect flop.
  - A rising edge is flagged 3 clk after the pin transition.
  - The fixed latency cancels out of period measurement.
- States:
  - IDLE: waits for arm.
  - ARMED: waits for the first rising edge.
  - MEASURE: times periods and tracks notes.
  - DONE: holds results.
- arm handling:
  - arm in any state: clear all results, then enter ARMED with capturing=1, done=0, overflow=0 on the next clk.
  - arm has priority over a coincident edge or timeout.
- ARMED:
  - First rising edge: clear the period counter, set Pcur=0 (no open note), go to MEASURE.
  - There is no timeout in ARMED; it waits indefinitely.
- MEASURE, period counter:
  - Increments every clk and saturates at 2^CNTW-1.
  - Each rising edge gives P = counter+1 (cycles since the previous rising edge), and the counter restarts at 0.
- MEASURE, note tracking on each rising edge:
  - No open note: open slot noteCount with Pcur=P, freq=P>>1, dur=1, noteCount+=1.
  - Open note and |P-Pcur|<=TOL: dur of the open slot += 1 (saturating). Pcur is not updated, so there is no drift.
  - Open note and |P-Pcur|>TOL, with noteCount<4: the open slot is final; open the next slot as above.
  - Open note and |P-Pcur|>TOL, with noteCount==4: set overflow=1 and go to DONE. Slots 0..3 keep their values.
- Period counting rules:
  - Periods are measured rising-to-rising.
  - The period spanning a note boundary belongs to the earlier note.
  - A trailing incomplete period after the last rising edge is discarded.
- Timeout: in MEASURE, counter reaching TIMEOUT-1 with no rising edge moves to DONE. This also covers pwm stuck high or stuck low.
- Entering DONE: capturing=0 and done=1 on the same clk edge. Outputs hold until arm or reset.
- Zero notes: first edge followed directly by timeout gives DONE with noteCount=0.
- Odd periods: P odd reports freq=(P-1)/2; the truncation is documented.

Test Plan:
- Reset mid-MEASURE, after 2 notes captured, reset_n low for 1 cycle: all outputs 0 immediately (asynchronously), state IDLE; a pwm edge without arm changes nothing.
- Two-note capture, after arm:
  - Stimulus: pwm with rising edges at t=0,6,12,18,24 (half-period 3), then 34,44,54 (half-period 5), then low.
  - Required: freq0=3, dur0=4, freq1=5, dur1=3, noteCount=2.
  - Timing: done=1 exactly TIMEOUT cycles after the edge at 54 is detected.
- Tolerance with TOL=1: periods 10,11,10,9 give one note (freq0=5, dur0=4); a following period 12 opens note 1.
- Overflow: five distinct notes with half-periods 2,4,6,8,10, each 2 periods; the 5th distinct period gives overflow=1, noteCount=4, freq3=8, DONE.
- Re-arm during MEASURE: arm pulse mid-note clears outputs next cycle, returns to ARMED (capturing=1), and the next capture of half-period 4 x3 periods gives freq0=4, dur0=3.
- Loopback: player configured with freq 3,5,1,2 drives pwm; captured freq0..3 equal 3,5,1,2.
